// File: rtl/matrix_result_drain.sv
// matrix_result_drain: captures the 3x3 systolic-array result matrix, saturates
// each element to OUT_W bits while building a threshold activation mask, and
// serves elements/status to the CPU through custom-0 PCPI instructions.
// Build option: define DRAIN_RELU_EN to store negative saturated values as 0.
module matrix_result_drain #(
  parameter int unsigned N_ELEM = 9,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  res_valid,
  input  logic [N_ELEM*32-1:0]  res_data,
  input  logic [31:0]           threshold,
  output logic                  res_ready,
  input  logic                  pcpi_valid,
  input  logic [31:0]           pcpi_insn,
  output logic                  pcpi_wr,
  output logic [31:0]           pcpi_rd,
  output logic                  pcpi_wait,
  output logic                  pcpi_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POST = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [6:0] OPCODE   = 7'b0001011;
  localparam logic [2:0] F3_ELEM  = 3'b010;
  localparam logic [2:0] F3_MASK  = 3'b011;
  localparam logic [2:0] F3_CLEAR = 3'b100;
  localparam logic [3:0] LAST_IDX = 4'(N_ELEM - 1);

  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -SAT_MAX - 32'sd1;

  state_t               state, state_next;
  logic [3:0]           idx;
  logic [N_ELEM-1:0]    mask;
  logic                 overflow;
  logic                 responded;
  logic signed [31:0]   thr;
  logic signed [31:0]   raw  [N_ELEM];
  logic [OUT_W-1:0]     elem [N_ELEM];

  logic [2:0]           funct3;
  logic [4:0]           sel;
  logic                 is_op, is_elem, is_mask, is_clear;
  logic                 pending, respond, clear_fire, capture;
  logic [OUT_W-1:0]     sat_val;
  logic                 cur_ge;
  logic [31:0]          rd_next;
  logic                 unused_insn_bits;

  assign funct3           = pcpi_insn[14:12];
  assign sel              = pcpi_insn[19:15];
  assign unused_insn_bits = ^{pcpi_insn[31:20], pcpi_insn[11:7]};

  assign is_op    = pcpi_valid && (pcpi_insn[6:0] == OPCODE);
  assign is_elem  = is_op && (funct3 == F3_ELEM);
  assign is_mask  = is_op && (funct3 == F3_MASK);
  assign is_clear = is_op && (funct3 == F3_CLEAR);

  // An instruction is pending until it has been answered once; an element read
  // during POST stalls the CPU until the full matrix has been processed.
  assign pending    = (is_elem || is_mask || is_clear) && !responded;
  assign pcpi_wait  = pending && is_elem && (state == POST);
  assign respond    = pending && !pcpi_wait;
  assign clear_fire = respond && is_clear;

  // A pending instruction also blocks capture, which is how CLEAR beats a
  // simultaneous res_valid without that matrix counting as an overflow.
  assign res_ready = (state != POST) && !pending;
  assign capture   = res_valid && res_ready;

  // Saturate and threshold-compare the element selected by idx.
  always_comb begin
    sat_val = raw[idx][OUT_W-1:0];
    if (raw[idx] > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (raw[idx] < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end
`ifdef DRAIN_RELU_EN
    if (raw[idx] < 0) begin
      sat_val = '0;
    end
`endif
    cur_ge = (raw[idx] >= thr);
  end

  // Read-data selection for the instruction being answered this cycle.
  always_comb begin
    rd_next = '0;
    if (is_elem) begin
      if (state != IDLE && sel < 5'(N_ELEM)) begin
        rd_next = {{(32 - OUT_W){elem[sel[3:0]][OUT_W-1]}}, elem[sel[3:0]]};
      end
    end else if (is_mask) begin
      rd_next = {overflow, 20'b0, state, mask};
    end
  end

  // Next-state logic: CLEAR has priority, then capture, then end of POST.
  always_comb begin
    state_next = state;
    if (clear_fire) begin
      state_next = IDLE;
    end else if (capture) begin
      state_next = POST;
    end else if (state == POST && idx == LAST_IDX) begin
      state_next = HOLD;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture, serial post-processing and overflow/mask bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      mask     <= '0;
      overflow <= 1'b0;
      thr      <= '0;
      for (int unsigned i = 0; i < N_ELEM; i++) begin
        raw[i]  <= '0;
        elem[i] <= '0;
      end
    end else begin
      if (state == POST) begin
        elem[idx] <= sat_val;
        mask[idx] <= cur_ge;
        idx       <= idx + 4'd1;
      end
      if (capture) begin
        for (int unsigned i = 0; i < N_ELEM; i++) begin
          raw[i] <= res_data[32*i +: 32];
        end
        thr  <= threshold;
        mask <= '0;
        idx  <= '0;
      end
      if (clear_fire) begin
        mask     <= '0;
        overflow <= 1'b0;
      end else if (res_valid && !res_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // PCPI response: one ready/wr pulse per instruction, rd zero outside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      responded  <= 1'b0;
    end else begin
      pcpi_ready <= respond;
      pcpi_wr    <= respond;
      pcpi_rd    <= respond ? rd_next : '0;
      responded  <= pcpi_valid && (responded || respond);
    end
  end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Self-checking bench for matrix_result_drain: directed scenarios plus random
// matrices compared against a time-based behavioural model.
module tb_matrix_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         res_valid;
  logic [287:0] res_data;
  logic [31:0]  threshold;
  logic         res_ready;
  logic         pcpi_valid;
  logic [31:0]  pcpi_insn;
  logic         pcpi_wr;
  logic [31:0]  pcpi_rd;
  logic         pcpi_wait;
  logic         pcpi_ready;

  always #5 clk = ~clk;

  matrix_result_drain #(.N_ELEM(9), .OUT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .threshold  (threshold),
    .res_ready  (res_ready),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  localparam logic [2:0] F_ELEM  = 3'b010;
  localparam logic [2:0] F_MASK  = 3'b011;
  localparam logic [2:0] F_CLEAR = 3'b100;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: matrix captured at edge cap_edge, element k done at cap_edge+1+k,
  // HOLD from hold_cyc = cap_edge+9 onward.
  bit have;
  bit ovf;
  int cap_edge;
  int hold_cyc;
  int raw_m [9];
  int thr_m;
  int stim_v [9];
  int stim_thr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int mstate();
    if (!have) return 0;
    if (cyc < hold_cyc) return 1;
    return 2;
  endfunction

  function automatic int exp_elem(input int i);
    int v;
    v = raw_m[i];
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  function automatic logic [8:0] mmask();
    logic [8:0] m;
    m = '0;
    for (int k = 0; k < 9; k++)
      if (have && cyc >= cap_edge + 1 + k && raw_m[k] >= thr_m) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] mstatus();
    logic [1:0] s;
    s = 2'(mstate());
    return {ovf, 20'b0, s, mmask()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic capture();
    bit exp_rdy;
    for (int i = 0; i < 9; i++) res_data[32*i +: 32] = stim_v[i];
    threshold = stim_thr;
    res_valid = 1'b1;
    #1;
    exp_rdy = (mstate() != 1);
    check("res_ready", res_ready, exp_rdy);
    tick();
    res_valid = 1'b0;
    if (exp_rdy) begin
      have     = 1'b1;
      cap_edge = cyc;
      hold_cyc = cyc + 9;
      for (int i = 0; i < 9; i++) raw_m[i] = stim_v[i];
      thr_m = stim_thr;
    end else begin
      ovf = 1'b1;
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [4:0] idx, output logic [31:0] rd_out);
    logic [31:0] exp_rd;
    int          exp_lat, lat, werr, extra;
    bit          exp_w;
    string       t;
    t = $sformatf("f%0d_i%0d", f3, idx);
    pcpi_insn  = {12'b0, idx, f3, 5'b0, 7'b0001011};
    pcpi_valid = 1'b1;
    exp_lat = 1;
    exp_rd  = '0;
    if (f3 == F_ELEM) begin
      if (mstate() == 1) exp_lat = hold_cyc + 1 - cyc;
      if (mstate() != 0 && idx < 9) exp_rd = exp_elem(int'(idx));
    end else if (f3 == F_MASK) begin
      exp_rd = mstatus();
    end
    lat  = 0;
    werr = 0;
    while (!pcpi_ready && lat < 40) begin
      #1;
      exp_w = (f3 == F_ELEM && mstate() == 1);
      if (pcpi_wait !== exp_w) werr++;
      tick();
      lat++;
    end
    check({t, "_ready"}, pcpi_ready, 1);
    check({t, "_wr"}, pcpi_wr, 1);
    check({t, "_latency"}, lat, exp_lat);
    check({t, "_rd"}, pcpi_rd, exp_rd);
    check({t, "_wait_cycles_wrong"}, werr, 0);
    rd_out = pcpi_rd;
    if (f3 == F_CLEAR && pcpi_ready) begin
      have = 1'b0;
      ovf  = 1'b0;
    end
    extra = 0;
    tick();
    check({t, "_rd_after"}, pcpi_rd, 0);
    if (pcpi_ready) extra++;
    tick();
    if (pcpi_ready) extra++;
    check({t, "_extra_pulses"}, extra, 0);
    pcpi_valid = 1'b0;
    tick();
  endtask

  task automatic load_directed();
    stim_v[0] = 100;    stim_v[1] = -5;  stim_v[2] = 70000;
    stim_v[3] = -70000; stim_v[4] = 0;   stim_v[5] = 69;
    stim_v[6] = 70;     stim_v[7] = -70; stim_v[8] = -71;
    stim_thr  = -70;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int pulses, werr;

    rst = 1'b1; res_valid = 1'b0; res_data = '0; threshold = '0;
    pcpi_valid = 1'b0; pcpi_insn = '0;
    have = 1'b0; ovf = 1'b0; cap_edge = 0; hold_cyc = 0; thr_m = 0;
    for (int i = 0; i < 9; i++) raw_m[i] = 0;
    idle(3);
    check("rst_ready", pcpi_ready, 0);
    check("rst_wr", pcpi_wr, 0);
    check("rst_rd", pcpi_rd, 0);
    check("rst_res_ready", res_ready, 1);
    check("rst_wait", pcpi_wait, 0);
    rst = 1'b0;
    tick();

    // Reads from an empty block.
    do_op(F_ELEM, 5'd0, rd);
    do_op(F_MASK, 5'd0, rd);
    check("empty_status", rd, 32'h0);

    // Directed matrix, read after processing completes.
    load_directed();
    capture();
    idle(10);
    do_op(F_ELEM, 5'd2, rd);
    check("dir_elem2", rd, 32'h0000_7FFF);
    do_op(F_ELEM, 5'd3, rd);
    do_op(F_ELEM, 5'd1, rd);
    do_op(F_MASK, 5'd0, rd);
    check("dir_mask", rd[10:0], {2'd2, 9'b011110111});

    // Element read issued right after capture stalls through POST.
    capture();
    do_op(F_ELEM, 5'd5, rd);
    check("stalled_elem5", rd, 32'd69);

    // Second matrix during POST is dropped and flags overflow.
    capture();
    idle(2);
    for (int i = 0; i < 9; i++) stim_v[i] = 1000 * (i + 1);
    capture();
    idle(10);
    do_op(F_MASK, 5'd0, rd);
    check("ovf_bit", rd[31], 1'b1);
    do_op(F_ELEM, 5'd5, rd);
    do_op(F_CLEAR, 5'd0, rd);
    do_op(F_MASK, 5'd0, rd);
    check("cleared_status", rd, 32'h0);

    // Out-of-range element index in HOLD.
    load_directed();
    capture();
    idle(10);
    do_op(F_ELEM, 5'd12, rd);

    // CLEAR and res_valid in the same cycle: CLEAR wins, no overflow.
    pcpi_insn  = {12'b0, 5'd0, F_CLEAR, 5'b0, 7'b0001011};
    pcpi_valid = 1'b1;
    for (int i = 0; i < 9; i++) res_data[32*i +: 32] = stim_v[i];
    res_valid = 1'b1;
    #1;
    check("clr_cap_res_ready", res_ready, 0);
    tick();
    res_valid = 1'b0;
    check("clr_cap_pcpi_ready", pcpi_ready, 1);
    have = 1'b0;
    ovf  = 1'b0;
    tick();
    pcpi_valid = 1'b0;
    tick();
    do_op(F_MASK, 5'd0, rd);
    check("clr_cap_status", rd, 32'h0);

    // Undecoded funct3 is ignored.
    pcpi_insn  = {12'b0, 5'd0, 3'b000, 5'b0, 7'b0001011};
    pcpi_valid = 1'b1;
    pulses = 0;
    werr   = 0;
    repeat (4) begin
      #1;
      if (pcpi_wait) werr++;
      tick();
      if (pcpi_ready) pulses++;
    end
    check("ignored_ready", pulses, 0);
    check("ignored_wait", werr, 0);
    pcpi_valid = 1'b0;
    tick();

    // Reset asserted in POST with an element read stalled.
    load_directed();
    capture();
    idle(2);
    pcpi_insn  = {12'b0, 5'd0, F_ELEM, 5'b0, 7'b0001011};
    pcpi_valid = 1'b1;
    #1;
    check("post_wait", pcpi_wait, 1);
    rst = 1'b1;
    tick();
    check("rst_post_wait", pcpi_wait, 0);
    check("rst_post_ready", pcpi_ready, 0);
    rst = 1'b0;
    pcpi_valid = 1'b0;
    have = 1'b0;
    ovf  = 1'b0;
    tick();
    check("rst_post_no_resp", pcpi_ready, 0);
    do_op(F_MASK, 5'd0, rd);

    // Random matrices and operations.
    for (int it = 0; it < 24; it++) begin
      stim_thr = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                             : int'($urandom_range(0, 400)) - 200;
      for (int i = 0; i < 9; i++) begin
        case ($urandom_range(0, 3))
          0: stim_v[i] = int'($urandom_range(0, 200)) - 100;
          1: stim_v[i] = int'($urandom);
          2: stim_v[i] = (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                         + int'($urandom_range(0, 4)) - 2;
          default: stim_v[i] = stim_thr + int'($urandom_range(0, 2)) - 1;
        endcase
      end
      capture();
      idle(int'($urandom_range(0, 12)));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 9; i++) stim_v[i] = -stim_v[i];
        capture();
      end
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 2) == 0) do_op(F_MASK, 5'd0, rd);
        else do_op(F_ELEM, 5'($urandom_range(0, 12)), rd);
      end
      if ($urandom_range(0, 2) == 0) do_op(F_CLEAR, 5'd0, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
